cdc_pulse_tx: RTL

CDC_PULSE_TX -- requirements
Module: cdc_pulse_tx

---
 rtl/cdc_pulse_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/cdc_pulse_tx.sv
// rtl/cdc_pulse_tx.sv - event-to-stretched-level transmitter with pending queue
// Each accepted event becomes one HIGH_CYCLES pulse followed by at least LOW_CYCLES low.
module cdc_pulse_tx #(
  parameter int HIGH_CYCLES = 6,
  parameter int LOW_CYCLES  = 6,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_event,
  input  logic              i_clr_ovf,
  output logic              o,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam int MAX_PHASE = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_d;
  logic              ovf_d;
  logic              o_d;
  logic              phase_last;
  logic              launch;
  logic              drop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = o_pending;
    ovf_d      = o_overflow;
    drop       = 1'b0;
    // Counter runs down to zero; zero marks the final cycle of the current phase.
    phase_last = (cnt_q == '0);
    launch     = ((state_q == IDLE) || ((state_q == LOW) && phase_last)) &&
                 ((o_pending != '0) || i_event);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
      end
      HIGH: begin
        if (phase_last) begin
          state_d = LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        if (phase_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (launch) begin
      state_d = HIGH;
      cnt_d   = HIGH_LOAD;
    end

    // A launch consumes the oldest queued event; a coincident new event takes its place.
    if (launch) begin
      if ((o_pending != '0) && !i_event) begin
        pend_d = o_pending - PEND_ONE;
      end
    end else if (i_event) begin
      if (o_pending != PEND_MAX) begin
        pend_d = o_pending + PEND_ONE;
      end else begin
        drop = 1'b1;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end

    o_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      o          <= 1'b0;
      o_pending  <= '0;
      o_overflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o          <= o_d;
      o_pending  <= pend_d;
      o_overflow <= ovf_d;
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
